// File: rtl/vx_stream_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_stream_pkt_arb
// Brief    : Weighted round-robin, packet-aware N:1 valid/ready stream
//            arbiter with an optional 2-entry skid buffer on the output.
// Revision : 1.0 - initial release
// ============================================================================
module vx_stream_pkt_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 32,
    parameter int WEIGHTW    = 4,
    parameter int OUT_REG    = 1,
    parameter int SELW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_INPUTS-1:0]         valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]   data_in,
    input  logic [NUM_INPUTS-1:0]         last_in,
    output logic [NUM_INPUTS-1:0]         ready_in,
    input  logic [NUM_INPUTS*WEIGHTW-1:0] weights,
    output logic                          valid_out,
    output logic [DATAW-1:0]              data_out,
    output logic                          last_out,
    output logic [SELW-1:0]               sel_out,
    input  logic                          ready_out
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [SELW-1:0]    owner;
    logic [SELW-1:0]    ptr;
    logic [WEIGHTW-1:0] cnt;

    logic [SELW-1:0]    grant;
    logic               has_grant;
    int                 search_idx;
    logic               int_ready;

    logic               beat_valid;
    logic               beat_xfer;
    logic               beat_last;
    logic [DATAW-1:0]   beat_data;

    logic [WEIGHTW-1:0] w_raw;
    logic [WEIGHTW-1:0] w_eff;
    logic [WEIGHTW-1:0] c_cur;
    logic [WEIGHTW:0]   c_inc;
    logic [SELW-1:0]    next_ptr;
    logic [WEIGHTW-1:0] next_cnt;

    // Grant selection: owner while a packet is open, otherwise the first
    // valid input searching circularly from ptr (lowest offset wins, so the
    // loop runs backwards and the last hit is kept).
    always_comb begin
        grant      = ptr;
        has_grant  = 1'b0;
        search_idx = 0;
        if (state == LOCKED) begin
            grant     = owner;
            has_grant = 1'b1;
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                search_idx = (int'(ptr) + k) % NUM_INPUTS;
                if (valid_in[search_idx]) begin
                    grant     = SELW'(search_idx);
                    has_grant = 1'b1;
                end
            end
        end
    end

    // Only the granted input sees ready; everyone else is stalled.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            ready_in[i] = int_ready & has_grant & (grant == SELW'(i));
        end
    end

    assign beat_valid = has_grant & valid_in[grant];
    assign beat_xfer  = beat_valid & int_ready;
    assign beat_last  = last_in[grant];
    assign beat_data  = data_in[int'(grant)*DATAW +: DATAW];

    // Weighted turn bookkeeping applied when a packet completes.
    always_comb begin
        w_raw = weights[int'(grant)*WEIGHTW +: WEIGHTW];
        w_eff = (w_raw == '0) ? WEIGHTW'(1) : w_raw;
        c_cur = (grant == ptr) ? cnt : '0;
        c_inc = {1'b0, c_cur} + 1'b1;
        if (c_inc < {1'b0, w_eff}) begin
            next_ptr = grant;
            next_cnt = c_inc[WEIGHTW-1:0];
        end else begin
            next_ptr = (grant == SELW'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
            next_cnt = '0;
        end
    end

    // Arbitration FSM: lock onto an input from first beat until its last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else if (beat_xfer) begin
            if (beat_last) begin
                state <= IDLE;
                ptr   <= next_ptr;
                cnt   <= next_cnt;
            end else if (state == IDLE) begin
                state <= LOCKED;
                owner <= grant;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             v0, v1;
            logic [DATAW-1:0] d0, d1;
            logic             l0, l1;
            logic [SELW-1:0]  s0, s1;
            logic             pop;

            // Accept only while the second slot is free; held off in reset.
            assign int_ready = reset_n & ~v1;
            assign pop       = v0 & ready_out;

            // Two-entry skid buffer; slot 0 is the output register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    v0 <= 1'b0;
                    v1 <= 1'b0;
                    d0 <= '0;
                    d1 <= '0;
                    l0 <= 1'b0;
                    l1 <= 1'b0;
                    s0 <= '0;
                    s1 <= '0;
                end else if (pop) begin
                    if (v1) begin
                        d0 <= d1;
                        l0 <= l1;
                        s0 <= s1;
                        v1 <= 1'b0;
                    end else if (beat_xfer) begin
                        d0 <= beat_data;
                        l0 <= beat_last;
                        s0 <= grant;
                    end else begin
                        v0 <= 1'b0;
                    end
                end else if (beat_xfer) begin
                    if (!v0) begin
                        d0 <= beat_data;
                        l0 <= beat_last;
                        s0 <= grant;
                        v0 <= 1'b1;
                    end else begin
                        d1 <= beat_data;
                        l1 <= beat_last;
                        s1 <= grant;
                        v1 <= 1'b1;
                    end
                end
            end

            assign valid_out = v0;
            assign data_out  = d0;
            assign last_out  = l0;
            assign sel_out   = s0;
        end else begin : g_out_comb
            // Zero-latency pass-through of the granted input.
            assign int_ready = reset_n & ready_out;
            assign valid_out = reset_n & beat_valid;
            assign data_out  = reset_n ? beat_data : '0;
            assign last_out  = reset_n & beat_last;
            assign sel_out   = reset_n ? grant : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vx_stream_pkt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_stream_pkt_arb
// Brief    : Scoreboard bench for vx_stream_pkt_arb (4-input registered
//            instance plus a 1-input combinational instance).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vx_stream_pkt_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int WW = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    valid_in, last_in, ready_in;
    logic [N*DW-1:0] data_in;
    logic [N*WW-1:0] weights;
    logic            valid_out, last_out, ready_out;
    logic [DW-1:0]   data_out;
    logic [SW-1:0]   sel_out;

    logic            s_valid_in, s_last_in, s_ready_in;
    logic            s_valid_out, s_last_out, s_ready_out;
    logic [DW-1:0]   s_data_in, s_data_out;
    logic [WW-1:0]   s_weights;
    logic [0:0]      s_sel_out;

    vx_stream_pkt_arb #(.NUM_INPUTS(N), .DATAW(DW), .WEIGHTW(WW), .OUT_REG(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_in(valid_in), .data_in(data_in), .last_in(last_in), .ready_in(ready_in),
        .weights(weights),
        .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
        .sel_out(sel_out), .ready_out(ready_out)
    );

    vx_stream_pkt_arb #(.NUM_INPUTS(1), .DATAW(DW), .WEIGHTW(WW), .OUT_REG(0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .valid_in(s_valid_in), .data_in(s_data_in), .last_in(s_last_in), .ready_in(s_ready_in),
        .weights(s_weights),
        .valid_out(s_valid_out), .data_out(s_data_out), .last_out(s_last_out),
        .sel_out(s_sel_out), .ready_out(s_ready_out)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int seq[N], out_seq[N], lim[N], plen[N];
    logic [DW-1:0] base[N];
    bit en[N];
    int exp_q[$];
    int first_out, last_out_cyc, n_out, start_cyc;
    bit chk_lock, lock2;

    // Source model: each input emits base+seq, last every plen beats, up to lim beats.
    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            valid_in[i] = en[i] && (seq[i] < lim[i]);
            data_in[i*DW +: DW] = base[i] + DW'(seq[i]);
            last_in[i] = ((seq[i] % plen[i]) == plen[i] - 1);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; out_seq[i] = 0; lim[i] = 0; plen[i] = 1;
            en[i] = 1'b0; base[i] = DW'(i) << 8;
        end
        exp_q.delete();
        n_out = 0; first_out = 0; last_out_cyc = 0;
        chk_lock = 1'b0; lock2 = 1'b0;
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        weights = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endtask

    // One clock: score output at the falling edge, account accepted beats,
    // then update inputs just after the rising edge.
    task automatic cycle();
        int s;
        logic [DW-1:0] ed;
        logic el;
        @(negedge clk);
        cyc++;
        if (chk_lock && lock2) begin
            checks++;
            if (ready_in[0] !== 1'b0) begin
                errors++;
                $display("FAIL lock_block: ready_in[0]=%b required 0", ready_in[0]);
            end
        end
        if (valid_out && ready_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: sel=%0d data=%h, no beat expected", sel_out, data_out);
            end else begin
                s = exp_q.pop_front();
                ed = base[s] + DW'(out_seq[s]);
                el = ((out_seq[s] % plen[s]) == plen[s] - 1);
                out_seq[s]++;
                if (sel_out !== SW'(s) || data_out !== ed || last_out !== el) begin
                    errors++;
                    $display("FAIL out_beat: got sel=%0d data=%h last=%b, required sel=%0d data=%h last=%b",
                             sel_out, data_out, last_out, s, ed, el);
                end
            end
            if (n_out == 0) first_out = cyc;
            last_out_cyc = cyc;
            n_out++;
        end
        for (int i = 0; i < N; i++) begin
            if (valid_in[i] && ready_in[i]) begin
                if (i == 2) lock2 = !last_in[2];
                seq[i]++;
            end
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic run_until_done(input int budget);
        int b;
        b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            cycle();
            b--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d beats still outstanding, required 0", exp_q.size());
        end
        repeat (4) cycle();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_model();
        ready_out = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_model();
        for (int i = 0; i < N; i++) begin en[i] = 1'b1; lim[i] = 100; end
        drive_inputs();
        s_valid_in = 1'b1; s_data_in = 32'h5; s_last_in = 1'b1; s_ready_out = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0 || last_out !== 1'b0 || sel_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h last=%b sel=%0d, required all 0",
                     valid_out, data_out, last_out, sel_out);
        end
        checks++;
        if (ready_in !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready_in: got %b required 0000", ready_in);
        end
        checks++;
        if (s_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb_valid: got %b required 0", s_valid_out);
        end
        s_valid_in = 1'b0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        set_weights(1, 1, 1, 1);
        for (int i = 0; i < N; i++) begin en[i] = 1'b1; lim[i] = 2; end
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) exp_q.push_back(i);
        start_cyc = cyc + 1;
        drive_inputs();
        run_until_done(40);
        checks++;
        if (first_out - start_cyc != 1) begin
            errors++;
            $display("FAIL rr_latency: first output %0d cycles after valid, required 1", first_out - start_cyc);
        end
        checks++;
        if (last_out_cyc - first_out != 7) begin
            errors++;
            $display("FAIL rr_back_to_back: 8 beats spanned %0d cycles, required 7", last_out_cyc - first_out);
        end
    endtask

    task automatic test_weights();
        int exp_a[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        apply_reset();
        set_weights(3, 1, 1, 1);
        en[0] = 1'b1; en[1] = 1'b1; lim[0] = 6; lim[1] = 2;
        foreach (exp_a[k]) exp_q.push_back(exp_a[k]);
        drive_inputs();
        run_until_done(40);
        apply_reset();
        set_weights(0, 1, 1, 1);
        en[0] = 1'b1; en[1] = 1'b1; lim[0] = 3; lim[1] = 3;
        for (int k = 0; k < 6; k++) exp_q.push_back(k % 2);
        drive_inputs();
        run_until_done(40);
    endtask

    task automatic test_packet_lock();
        int exp_a[7] = '{0, 2, 2, 2, 2, 0, 0};
        apply_reset();
        set_weights(1, 1, 1, 1);
        en[0] = 1'b1; en[2] = 1'b1; lim[0] = 3; lim[2] = 4; plen[2] = 4;
        foreach (exp_a[k]) exp_q.push_back(exp_a[k]);
        chk_lock = 1'b1;
        drive_inputs();
        run_until_done(40);
        chk_lock = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_weights(1, 1, 1, 1);
        en[1] = 1'b1; lim[1] = 6; base[1] = 32'hA0;
        ready_out = 1'b0;
        drive_inputs();
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (valid_out !== 1'b1 || data_out !== 32'hA0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h, required 1 and a0", valid_out, data_out);
            end
        end
        checks++;
        if (seq[1] != 2) begin
            errors++;
            $display("FAIL stall_accepts: %0d beats accepted, required 2", seq[1]);
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(1);
        ready_out = 1'b1;
        run_until_done(40);
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        set_weights(1, 1, 1, 1);
        en[2] = 1'b1; lim[2] = 3; plen[2] = 3;
        for (int k = 0; k < 3; k++) exp_q.push_back(2);
        drive_inputs();
        cycle();
        cycle();
        checks++;
        if (valid_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_pkt_valid: got %b required 1", valid_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== '0 || sel_out !== '0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h sel=%0d, required 0", valid_out, data_out, sel_out);
        end
        clear_model();
        drive_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1; lim[0] = 1; lim[1] = 1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        drive_inputs();
        run_until_done(20);
    endtask

    task automatic test_comb_passthrough();
        logic [DW-1:0] exp_d;
        s_weights = 4'd1;
        s_valid_in = 1'b1;
        s_last_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_d = (k < 4) ? 32'h5 : 32'h1234_5678;
            s_data_in = exp_d;
            s_ready_out = k[0];
            #1;
            checks++;
            if (s_valid_out !== 1'b1 || s_data_out !== exp_d || s_sel_out !== 1'b0) begin
                errors++;
                $display("FAIL comb_data: valid=%b data=%h sel=%0d, required 1 %h 0",
                         s_valid_out, s_data_out, s_sel_out, exp_d);
            end
            checks++;
            if (s_ready_in !== k[0]) begin
                errors++;
                $display("FAIL comb_ready: ready_in=%b required %b", s_ready_in, k[0]);
            end
        end
        s_valid_in = 1'b0;
        #1;
        checks++;
        if (s_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL comb_idle: valid_out=%b required 0", s_valid_out);
        end
    endtask

    initial begin
        valid_in = '0; data_in = '0; last_in = '0; ready_out = 1'b1;
        set_weights(1, 1, 1, 1);
        s_valid_in = 1'b0; s_data_in = '0; s_last_in = 1'b0; s_ready_out = 1'b0; s_weights = 4'd1;
        test_reset();
        test_round_robin();
        test_weights();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_comb_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
